// File: rtl/dct_coef_writer_pkg.sv
// Shared constants, state encoding and checksum helper for the DCT coefficient writer.
package dct_pkg;

  localparam int COEF_W        = 11;
  localparam int N_COEF        = 16;
  localparam int PIX_W         = 8;
  localparam int COEF_PER_WORD = 4;
  localparam int N_ROWS        = 16;
  localparam int ADDR_W        = 6;

  localparam int ROW_W     = N_COEF * COEF_W;
  localparam int PIX_ROW_W = N_COEF * PIX_W;
  localparam int WORD_W    = COEF_PER_WORD * COEF_W;
  localparam int WPR       = N_COEF / COEF_PER_WORD;
  localparam int BEAT_W    = $clog2(WPR);
  localparam int ROWCNT_W  = $clog2(N_ROWS);
  localparam int CSUM_W    = 20;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  // Sign-extended sum of every coefficient in one row.
  function automatic logic signed [CSUM_W-1:0] row_sum(input logic [ROW_W-1:0] row);
    logic signed [CSUM_W-1:0] acc;
    logic [COEF_W-1:0]        c;
    acc = '0;
    for (int i = 0; i < N_COEF; i++) begin
      c   = row[i*COEF_W +: COEF_W];
      acc = acc + {{(CSUM_W-COEF_W){c[COEF_W-1]}}, c};
    end
    return acc;
  endfunction

endpackage

// File: rtl/dct_coef_writer_if.sv
// Row handshake, result-memory write port and status of dct_coef_writer.
// The checksum signal exists only when DCT_WRITER_CHECKSUM_EN is defined.
interface dct_coef_writer_if;
  import dct_pkg::*;

  logic              start;
  logic              coef_valid;
  logic              coef_ready;
  logic [ROW_W-1:0]  coef_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              busy;
  logic              frame_done;
`ifdef DCT_WRITER_CHECKSUM_EN
  logic signed [CSUM_W-1:0] checksum;
`endif

  modport master (
    output start, coef_valid, coef_data,
`ifdef DCT_WRITER_CHECKSUM_EN
    input  checksum,
`endif
    input  coef_ready, mem_we, mem_addr, mem_wdata, busy, frame_done
  );

  modport slave (
    input  start, coef_valid, coef_data,
`ifdef DCT_WRITER_CHECKSUM_EN
    output checksum,
`endif
    output coef_ready, mem_we, mem_addr, mem_wdata, busy, frame_done
  );

endinterface

// File: rtl/dct_row_serializer.sv
// Holds one coefficient row and presents it one memory word per beat, lane 0 first.
module dct_row_serializer
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  input  logic [ROW_W-1:0]  row_in,
  output logic [WORD_W-1:0] word,
  output logic [BEAT_W-1:0] beat,
  output logic              last_beat
);

  logic [ROW_W-1:0] row_reg;

  // Shifting the row down keeps the output word a direct register slice.
  always_ff @(posedge clk) begin
    if (rstn) begin
      row_reg <= '0;
      beat    <= '0;
    end else if (load) begin
      row_reg <= row_in;
      beat    <= '0;
    end else if (advance) begin
      row_reg <= row_reg >> WORD_W;
      beat    <= beat + BEAT_W'(1);
    end else if (clear) begin
      beat    <= '0;
    end
  end

  assign word      = row_reg[WORD_W-1:0];
  assign last_beat = (beat == BEAT_W'(WPR-1));

endmodule

// File: rtl/dct_coef_writer.sv
// Drains 176-bit DCT coefficient rows into the result memory, four coefficients per word.
// Define DCT_WRITER_CHECKSUM_EN to add a running checksum of all accepted coefficients.
module dct_coef_writer
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  dct_coef_writer_if.slave  bus
);

  localparam logic [ROWCNT_W-1:0] LAST_ROW  = ROWCNT_W'(N_ROWS-1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(WPR-1);

  state_t               state, state_next;
  logic [ROWCNT_W-1:0]  row, row_next;
  logic [BEAT_W-1:0]    beat, beat_next;
  logic                 last_beat;
  logic                 load, advance, clear;

  logic                 coef_ready_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic                 busy_q;
  logic                 frame_done_q;

  dct_row_serializer u_serializer (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .load      (load),
    .advance   (advance),
    .row_in    (bus.coef_data),
    .word      (bus.mem_wdata),
    .beat      (beat),
    .last_beat (last_beat)
  );

  always_comb begin
    state_next = state;
    row_next   = row;
    load       = 1'b0;
    advance    = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clear      = 1'b1;
          row_next   = '0;
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        if (bus.coef_valid && coef_ready_q) begin
          load       = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!last_beat) begin
          advance = 1'b1;
        end else if (row == LAST_ROW) begin
          state_next = DONE;
        end else begin
          row_next = row + ROWCNT_W'(1);
          // A row waiting on the last beat is taken straight away for back-to-back writes.
          if (bus.coef_valid && coef_ready_q) begin
            load = 1'b1;
          end else begin
            state_next = ACCEPT;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    beat_next = (load || clear) ? '0 : (advance ? beat + BEAT_W'(1) : beat);
  end

  // Outputs are computed from the next state so every port leaves a flop.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= IDLE;
      row          <= '0;
      coef_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      row          <= row_next;
      coef_ready_q <= (state_next == ACCEPT) ||
                      (state_next == WRITE && beat_next == LAST_BEAT && row_next != LAST_ROW);
      mem_we_q     <= (state_next == WRITE);
      if (state_next == WRITE) begin
        mem_addr_q <= ADDR_W'(int'(row_next) * WPR + int'(beat_next));
      end
      busy_q       <= (state_next == ACCEPT) || (state_next == WRITE);
      frame_done_q <= (state_next == DONE);
    end
  end

  assign bus.coef_ready = coef_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

`ifdef DCT_WRITER_CHECKSUM_EN
  logic signed [CSUM_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      checksum_q <= '0;
    end else if (clear) begin
      checksum_q <= '0;
    end else if (load) begin
      checksum_q <= checksum_q + row_sum(bus.coef_data);
    end
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: doc/dct_coef_writer.md
Name: dct_coef_writer

Overview:
- Drain end of the DCT datapath: the DCT core reads pixel rows from the input memory and emits one 176-bit coefficient row at a time. This block accepts those rows and writes them into the output result memory.
- Each row holds 16 coefficients of 11 bits. The block serialises each row into narrower memory words and generates addresses.
- Raises a one-cycle frame-complete pulse when a full frame is stored. The bench then dumps the output memory and compares it against the reference coefficient file.

Parameters:
- N_COEF, 16, coefficients per row
- COEF_W, 11, coefficient width (signed two's complement)
- COEF_PER_WORD, 4, coefficients packed per memory word
- N_ROWS, 16, rows per frame
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W >= N_ROWS*N_COEF/COEF_PER_WORD

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous, active-high reset (asserted = 1)
- start  in  1  one-cycle pulse that arms a new frame
- coef_valid  in  1  coefficient row valid
- coef_ready  out  1  block accepts a row this cycle
- coef_data  in  N_COEF*COEF_W (176)  coefficient row; coef 0 in bits [10:0]
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  COEF_PER_WORD*COEF_W (44)  memory word
- busy  out  1  high from start until frame_done
- frame_done  out  1  one-cycle pulse after the last write

Behaviour:
- Derived constants: WPR = N_COEF/COEF_PER_WORD = 4 words per row. Frame spans N_ROWS*WPR = 64 words.
- Reset (rstn=1 at an edge) forces all outputs to 0, state IDLE, and row/beat counters to 0. Reset mid-frame abandons the frame with no further writes.
- IDLE:
  - coef_ready=0 and busy=0.
  - start=1 clears counters and enters ACCEPT.
  - coef_valid in IDLE is ignored; the row is not consumed.
- ACCEPT:
  - coef_ready=1 and busy=1.
  - On coef_valid&&coef_ready, coef_data is latched into the row register, beat=0, and the state moves to WRITE.
- WRITE:
  - Each cycle drives mem_we=1, mem_addr=row*WPR+beat, and mem_wdata=coefficients beat*4..beat*4+3.
  - Lane i of the word occupies bits [i*11+10:i*11].
  - beat increments each cycle.
- Last beat (beat==WPR-1):
  - If row<N_ROWS-1: coef_ready=1 this cycle. If a row is accepted, it loads and WRITE continues with beat=0, row+1 (back-to-back, sustained 1 row per 4 cycles). Otherwise go to ACCEPT with row+1.
  - If row==N_ROWS-1: coef_ready=0 and go to DONE.
- DONE: frame_done=1 for exactly one cycle, then busy=0 and IDLE.
- Latency: a row accepted at edge t produces its first mem_we in the cycle after t. All outputs are registered.
- start while busy is ignored.
- start in the same cycle as DONE is ignored; a new start is needed in IDLE.
- coef_data is sampled only on handshake. It may change freely while coef_ready=0.
- mem_addr never exceeds N_ROWS*WPR-1. There is no wrap within a frame.

Optional Feature:
- Macro: DCT_WRITER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (20-bit signed).
  - Cleared on start.
  - Accumulates the sign-extended sum of all 16 coefficients of each accepted row, updated on the handshake cycle.
  - Stable and valid from the frame_done cycle until the next start or reset.
  - Reset value 0.
- When undefined: the port and accumulator are absent, and all other behaviour is identical.

Decomposition:
- Shared package dct_pkg holds:
  - COEF_W, N_COEF, PIX_W (8)
  - Row widths: coefficient row 176, pixel row 128
  - WPR
  - State encoding: IDLE, ACCEPT, WRITE, DONE
- Natural sub-module: dct_row_serializer. It holds the 176-bit row register and the beat counter, and outputs the 44-bit lane-selected word plus a last_beat flag. The parent holds the FSM, row counter, addressing and the optional checksum.

Test Plan:
- Reset mid-frame:
  - Stimulus: start, one row accepted, rstn=1 during beat 2.
  - Required: mem_we=0 from the next cycle, busy=0, coef_ready=0, and no further writes until a new start.
- Single-row address and packing:
  - Stimulus: start, row 0 with coef j = j+1.
  - Required: writes to addr 0..3. Addr 0 wdata has lanes {1,2,3,4} (lane 0 = 1). Addr 3 holds {13,14,15,16}.
  - The first mem_we is in the cycle after the handshake.
- Back-to-back full frame:
  - Stimulus: 16 rows with coef_valid held high.
  - Required: exactly 64 contiguous mem_we cycles, addr 0..63, rows accepted every 4 cycles.
  - frame_done pulses once, the cycle after addr 63. busy drops with it.
- Backpressure gaps:
  - Stimulus: rows presented with random 0–5 idle cycles.
  - Required: identical memory contents to the back-to-back case, no dropped or duplicated words, and coef_data changes while coef_ready=0 have no effect.
- Ignored start, and full-frame checksum (DCT_WRITER_CHECKSUM_EN):
  - Stimulus: start pulsed mid-frame.
  - Required: row counter unaffected.
  - Stimulus: all coefficients = -1024 (0x400) over 16 rows.
  - Required: checksum = -262144 at frame_done.
